// File: rtl/accel_dispatch_if.sv
// Bus bundle between the CPU decode stage, the accelerator engines and the
// dispatcher. The master side is the decode stage plus the engines. The slave
// side is the dispatcher.
interface accel_dispatch_if #(
   parameter int IDX_W = 11
);
   // Decode-side request handshake
   logic             req_valid;
   logic [1:0]       req_type;
   logic [IDX_W-1:0] req_index;
   logic             req_ready;
   logic             stall;

   // Engine control
   logic             h_start;
   logic             e_start;
   logic             d_start;
   logic [IDX_W-1:0] acc_index;
   logic             h_done;
   logic             e_done;
   logic             d_done;

   // Status back to the CPU
   logic             busy;
   logic             irq;
   logic [1:0]       irq_type;
   logic             abort;
   logic             err_timeout;
   logic             err_illegal;
   logic             err_clr;

   modport master (
      output req_valid, req_type, req_index, h_done, e_done, d_done, err_clr,
      input  req_ready, stall, h_start, e_start, d_start, acc_index,
             busy, irq, irq_type, abort, err_timeout, err_illegal
   );

   modport slave (
      input  req_valid, req_type, req_index, h_done, e_done, d_done, err_clr,
      output req_ready, stall, h_start, e_start, d_start, acc_index,
             busy, irq, irq_type, abort, err_timeout, err_illegal
   );
endinterface

// File: rtl/accel_dispatch.sv
// Accelerator launch dispatcher. Launch requests from decode go into a small
// FIFO. The dispatcher then runs one job at a time on the shared accelerator
// port: start pulse, wait for the matching done, then raise irq. If no done
// arrives in time, the watchdog aborts the job.
module accel_dispatch #(
   parameter int QDEPTH  = 4,
   parameter int IDX_W   = 11,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   accel_dispatch_if.slave bus
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam int ENT_W = IDX_W + 2;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [1:0]       T_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE,
      ST_ABORT
   } state_t;

   // FIFO storage and bookkeeping
   logic [ENT_W-1:0] fifo_mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ENT_W-1:0] head;
   logic [1:0]       head_type;
   logic [IDX_W-1:0] head_index;

   // Handshake decode
   logic req_ready;
   logic accept;
   logic push;
   logic pop;
   logic illegal_seen;

   // Sequencer
   state_t           state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [1:0]       cur_type_q, cur_type_d;
   logic             cur_done;

   // Registered outputs
   logic [2:0]       start_q, start_d;
   logic             irq_q, irq_d;
   logic             abort_q, abort_d;
   logic [1:0]       irq_type_q, irq_type_d;
   logic [IDX_W-1:0] acc_index_q, acc_index_d;
   logic             busy_q, busy_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_illegal_q, err_illegal_d;

   // ------------------------------------------------------------------
   // Request handshake. An illegal type still completes the handshake,
   // but it never enters the FIFO.
   // ------------------------------------------------------------------
   assign req_ready    = (count_q != CNT_FULL);
   assign accept       = bus.req_valid & req_ready;
   assign illegal_seen = accept & (bus.req_type == T_ILLEGAL);
   assign push         = accept & (bus.req_type != T_ILLEGAL);

   assign head       = fifo_mem[rd_ptr_q];
   assign head_type  = head[ENT_W-1:IDX_W];
   assign head_index = head[IDX_W-1:0];

   // Write accepted legal requests into the FIFO (data needs no reset)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {bus.req_type, bus.req_index};
      end
   end

   // Occupancy: a push and a pop in the same cycle cancel out
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // FIFO pointers and count. QDEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Done line of the engine that owns the current job; other dones are ignored
   always_comb begin
      cur_done = 1'b0;
      unique case (cur_type_q)
         2'b00:   cur_done = bus.h_done;
         2'b01:   cur_done = bus.e_done;
         2'b10:   cur_done = bus.d_done;
         default: cur_done = 1'b0;
      endcase
   end

   // Sequencer next state. The head is popped on the IDLE->LAUNCH transition.
   // A done that arrives on the last watchdog cycle wins over the abort.
   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      cur_type_d = cur_type_q;
      pop        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               cur_type_d = head_type;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cur_done) begin
               state_d = ST_DONE;
            end else if (wd_q == WD_LAST) begin
               state_d = ST_ABORT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Sequencer state, watchdog and current-job type
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wd_q       <= '0;
         cur_type_q <= '0;
      end else begin
         state_q    <= state_d;
         wd_q       <= wd_d;
         cur_type_q <= cur_type_d;
      end
   end

   // One start pulse per engine. Each pulse is raised in the LAUNCH cycle
   // for the popped type only.
   for (genvar gi = 0; gi < 3; gi++) begin : g_start
      assign start_d[gi] = pop & (head_type == 2'(gi));
   end

   // Next values of the registered outputs. They are derived from the next state,
   // so each output lines up with the state it belongs to. Clear beats a same-cycle set.
   always_comb begin
      irq_d         = (state_d == ST_DONE);
      abort_d       = (state_d == ST_ABORT);
      irq_type_d    = irq_type_q;
      acc_index_d   = acc_index_q;
      busy_d        = (state_d != ST_IDLE) || (count_d != '0);
      err_timeout_d = err_timeout_q;
      err_illegal_d = err_illegal_q;
      if (pop) begin
         acc_index_d = head_index;
      end
      if (irq_d || abort_d) begin
         irq_type_d = cur_type_q;
      end
      if (bus.err_clr) begin
         err_timeout_d = 1'b0;
         err_illegal_d = 1'b0;
      end else begin
         err_timeout_d = err_timeout_q | abort_d;
         err_illegal_d = err_illegal_q | illegal_seen;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q       <= '0;
         irq_q         <= 1'b0;
         abort_q       <= 1'b0;
         irq_type_q    <= '0;
         acc_index_q   <= '0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         start_q       <= start_d;
         irq_q         <= irq_d;
         abort_q       <= abort_d;
         irq_type_q    <= irq_type_d;
         acc_index_q   <= acc_index_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
         err_illegal_q <= err_illegal_d;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.stall       = bus.req_valid & ~req_ready;
   assign bus.h_start     = start_q[0];
   assign bus.e_start     = start_q[1];
   assign bus.d_start     = start_q[2];
   assign bus.acc_index   = acc_index_q;
   assign bus.busy        = busy_q;
   assign bus.irq         = irq_q;
   assign bus.irq_type    = irq_type_q;
   assign bus.abort       = abort_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.err_illegal = err_illegal_q;

endmodule
